// File: rtl/handshake_4phase_rx.sv
// Receiving end of a 4-phase (return-to-zero) req/ack link, terminating into a
// single-clock valid/ready stream. At most one word is in flight.
module handshake_4phase_rx #(
  parameter int DataWidth  = 32,
  parameter int SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 ack_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [1:0]           state_o
);

  // Stream handshake: a word moves on a clk_i edge where valid_o && ready_i;
  // once valid_o is high it and data_o hold until that edge, and ready_i may
  // be high before valid_o rises.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 req_s;

  if (SyncStages == 0) begin : g_no_sync
    assign req_s = req_i;
  end else begin : g_sync
    logic [SyncStages-1:0] sync_q, sync_d;

    always_comb begin
      sync_d[0] = req_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign req_s = sync_q[SyncStages-1];
  end

  // data_i is bundled: it is only looked at once req_s is high, when it has settled.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          data_d  = data_i;
          state_d = VALID;
        end
      end
      VALID: begin
        if (ready_i) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == VALID);
    ack_d   = (state_d == ACK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_o   = ack_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign state_o = state_q;

`ifndef SYNTHESIS
  // Counts req_i dropping before the word was acknowledged.
  logic        req_prev_q;
  int unsigned viol_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_prev_q <= 1'b0;
      viol_cnt   <= 0;
    end else begin
      req_prev_q <= req_i;
      if (state_q == VALID && req_prev_q && !req_i && !ack_o) begin
        viol_cnt <= viol_cnt + 1;
      end
    end
  end

  a_stream_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> ($stable(valid_o) && $stable(data_o)))
    else $error("valid_o/data_o changed while stalled");
`endif

endmodule
